// File: rtl/mux_pkg.sv
// mux_pkg: shared definitions for the round-robin channel mux.
//   MODE_FIXED / MODE_RR : encodings of the 'mode' input.
//   DEF_WIDTH / DEF_N    : default data width and channel count.
//   idx_in_range()       : true when a channel index addresses an existing channel.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_N     = 8;

  function automatic logic idx_in_range(input int idx, input int n);
    return (idx >= 0) && (idx < n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req     [N]     : request vector.
//   ptr     [SEL_W] : last served channel; search starts at ptr+1.
//   gnt_vld         : some request won.
//   gnt     [SEL_W] : winning channel index.
// The request vector is doubled so the wrap from N-1 back to 0 becomes a
// plain lowest-set-bit search above ptr in a 2N-wide vector.
module rr_arbiter #(
  parameter int N     = 8,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             gnt_vld,
  output logic [SEL_W-1:0] gnt
);

  // cand[j] : request of channel (j mod N), kept only above the pointer.
  // The upper copy covers channels 0..ptr after the wrap, ptr itself last.
  logic [2*N-1:0] cand;

  genvar gi;
  generate
    for (gi = 0; gi < 2*N; gi++) begin : g_cand
      assign cand[gi] = req[gi % N] && (gi > int'(ptr));
    end
  endgenerate

  // Scan downward so the lowest candidate is the last one written.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    for (int j = 2*N-1; j >= 0; j--) begin
      if (cand[j]) begin
        gnt_vld = 1'b1;
        gnt     = (j >= N) ? SEL_W'(j - N) : SEL_W'(j);
      end
    end
  end

endmodule

// File: rtl/rr_channel_mux.sv
// rr_channel_mux: N-to-1 valid/ready channel selector with a registered output.
//   clk, reset_n        : clock, asynchronous active-low reset.
//   in_data  [N*WIDTH]  : channel i at bits [i*WIDTH +: WIDTH].
//   in_valid [N]        : per-channel valid.
//   in_ready [N]        : per-channel ready, at most one bit set.
//   mode                : MODE_FIXED uses 'sel', MODE_RR arbitrates round-robin.
//   sel      [SEL_W]    : fixed-mode channel; values >= N never grant.
//   out_data [WIDTH]    : registered beat data.
//   out_valid           : output register holds a beat.
//   out_ready           : consumer accepts the beat.
//   out_ch   [SEL_W]    : source channel of the current beat.
module rr_channel_mux
  import mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N,
  parameter int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_ch
);

  // Index space padded to a power of two so any SEL_W value is a legal index.
  localparam int NP = 1 << SEL_W;

  logic [WIDTH-1:0] out_data_reg;
  logic             out_valid_reg;
  logic [SEL_W-1:0] out_ch_reg;
  logic [SEL_W-1:0] rr_ptr_reg;

  logic             load_en;
  logic             rr_vld;
  logic [SEL_W-1:0] rr_gnt;
  logic             fix_vld;
  logic             grant_vld;
  logic [SEL_W-1:0] grant;
  logic [NP-1:0]    valid_pad;
  logic [WIDTH-1:0] ch_data [NP];

  genvar gi;
  generate
    for (gi = 0; gi < NP; gi++) begin : g_chan
      if (gi < N) begin : g_real
        assign ch_data[gi]   = in_data[gi*WIDTH +: WIDTH];
        assign valid_pad[gi] = in_valid[gi];
      end else begin : g_pad
        assign ch_data[gi]   = '0;
        assign valid_pad[gi] = 1'b0;
      end
    end
  endgenerate

  rr_arbiter #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr_reg),
    .gnt_vld (rr_vld),
    .gnt     (rr_gnt)
  );

  // Output register can take a beat when empty or draining this cycle.
  assign load_en = !out_valid_reg || out_ready;

  always_comb begin
    fix_vld = 1'b0;
    if (idx_in_range(int'(sel), N)) begin
      fix_vld = valid_pad[sel];
    end
    if (mode == MODE_RR) begin
      grant_vld = rr_vld;
      grant     = rr_gnt;
    end else begin
      grant_vld = fix_vld;
      grant     = sel;
    end
  end

  generate
    for (gi = 0; gi < N; gi++) begin : g_ready
      assign in_ready[gi] = load_en && grant_vld && (grant == SEL_W'(gi));
    end
  endgenerate

  // A granted channel is valid by construction, so load_en && grant_vld is
  // exactly the accepted transfer. The pointer follows every accepted beat,
  // fixed mode included, so round-robin resumes after the last served channel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      rr_ptr_reg    <= SEL_W'(N - 1);
    end else if (load_en) begin
      if (grant_vld) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= ch_data[grant];
        out_ch_reg    <= grant;
        rr_ptr_reg    <= grant;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign out_ch    = out_ch_reg;

endmodule

// File: doc/rr_channel_mux.md
Name: rr_channel_mux

Overview:
- Parametrised N-to-1 data channel selector: successor to the combinational 8-way 32-bit select mux.
- Adds per-channel valid/ready handshakes, a registered output stage and two modes: fixed-select (software `sel`) and round-robin arbitration.
- Sits between multiple producer channels and a single consumer; provides backpressure and records which source channel each output beat came from.

Parameters:
- WIDTH, 32, data width per channel.
- N, 8, number of input channels (2..32; need not be a power of two).
- SEL_W, $clog2(N), width of channel index (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_data  input  N*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; at most one bit high per cycle.
- mode  input  1  0 = fixed-select, 1 = round-robin.
- sel  input  SEL_W  channel index used in fixed-select mode.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  out_data/out_ch hold a beat.
- out_ready  input  1  consumer accepts beat.
- out_ch  output  SEL_W  source channel of current out beat.

Behaviour:
- Reset (async, reset_n=0): out_valid=0, out_data=0, out_ch=0, rr_ptr=N-1, so channel 0 has first round-robin priority. in_ready is combinational and reads 0 while out_valid=0 holds with no valid input.
- load_en = !out_valid || out_ready. The output register accepts a new beat when empty, or in the same cycle the current beat drains (full throughput, 1 beat/cycle).
- Grant, combinational:
  - Fixed mode: grant_vld = (sel < N) && in_valid[sel]; grant = sel. sel >= N means no grant ever.
  - Round-robin mode: scan channels rr_ptr+1, rr_ptr+2, ... modulo N (wrap N-1 -> 0). The first with in_valid=1 wins; grant_vld=0 if none are valid.
- in_ready[i] = load_en && grant_vld && (grant == i). All other bits are 0.
- Transfer on channel i: in_valid[i] && in_ready[i]. On the next edge: out_data <= channel i data, out_ch <= i, out_valid <= 1.
- Latency: input handshake to out_valid is 1 cycle. There is no combinational path from in_data to out_data.
- out_ready=1 with no grant: out_valid <= 0 on the next edge.
- out_valid=1 && out_ready=0:
  - The output register holds out_data/out_ch stable.
  - All in_ready bits are 0.
  - rr_ptr is unchanged.
- rr_ptr updates to grant only on an accepted transfer. Fixed-mode transfers also update rr_ptr, so a switch to round-robin continues fairly from the last served channel.
- mode and sel are sampled combinationally each cycle. A change affects the next grant decision only, never a beat already registered.
- Producers must hold in_data/in_valid until handshake. The block does not drop or duplicate beats.
- Reset asserted mid-transfer: the beat is discarded, out_valid is forced to 0 immediately, and rr_ptr returns to N-1.
- All channels valid in round-robin mode: grants rotate 0,1,...,N-1,0 with one grant per accepted cycle.

Decomposition:
- Shared package mux_pkg:
  - MODE_FIXED=1'b0, MODE_RR=1'b1.
  - Default WIDTH/N localparams.
  - Helper function for in-range index check.
- One sub-module is natural: rr_arbiter (purely combinational; params N, SEL_W).
  - Inputs: req[N], ptr[SEL_W].
  - Outputs: gnt_vld, gnt[SEL_W].
  - Implementation: double-width masked priority search.
- The top level owns the output register, rr_ptr register and handshake logic.

Test Plan:
- Reset then idle: reset_n low 3 cycles, release, all in_valid=0 -> out_valid=0, out_data=0, out_ch=0, in_ready=0.
- Fixed mode, sel=5, ch5 data=32'hA5A5_0005, in_valid=8'hFF, out_ready=1:
  - Only in_ready[5]=1.
  - One cycle later out_data=32'hA5A5_0005, out_ch=5.
  - Repeats every cycle.
- Round-robin, all 8 valid, out_ready=1 -> out_ch sequence 0,1,2,...,7,0 on consecutive cycles; with N=5 instance, sequence 0..4,0 (wrap check).
- Round-robin, in_valid=8'b1000_0100, rr_ptr=2 -> ch7 granted, then ch2; out_ready=0 for 3 cycles stalls: out_data stable, in_ready=0, rr_ptr unchanged.
- Fixed mode sel=6 with N=5 instance -> no grant, out_valid stays 0; switch mode=1 mid-stream -> next grant follows last served channel +1.
- Assert reset_n while out_valid=1 with stalled beat -> out_valid=0 immediately (asynchronous); after release, round-robin restarts at channel 0.
